// File: rtl/sram_ctrl.sv
// sram_ctrl: registered, wait-state-aware bridge from an Avalon-style slave port to an async SRAM.
// Define SRAM_CTRL_STATS_EN to add saturating rd_count/wr_count access counters.
//
// state | meaning
// IDLE  | strobes high, DQ released, waiting for a slave request
// READ  | CE_n/OE_n low for RD_WAIT+1 cycles, DQ sampled on the last edge
// WRITE | CE_n/WE_n low for WR_WAIT+1 cycles, latched data driven on DQ
// DONE  | single cycle with waitrequest low; write data still held on DQ
// TURN  | TURN cycles with DQ released and all strobes high
module sram_ctrl #(
    parameter int  DATA_W  = 16,
    parameter int  ADDR_W  = 18,
    parameter int  RD_WAIT = 1,
    parameter int  WR_WAIT = 1,
    parameter int  TURN    = 1,
    localparam int BE_W    = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_chipselect_n,
    input  logic              s_read_n,
    input  logic              s_write_n,
    input  logic [BE_W-1:0]   s_byteenable_n,
    input  logic [ADDR_W-1:0] s_address,
    input  logic [DATA_W-1:0] s_writedata,
    output logic [DATA_W-1:0] s_readdata,
    output logic              s_waitrequest,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic [BE_W-1:0]   SRAM_BE_n,
    output logic              SRAM_CE_n,
    output logic              SRAM_OE_n,
    output logic              SRAM_WE_n
`ifdef SRAM_CTRL_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_TURN  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_lat_q, be_lat_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_acc_q, wr_acc_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              waitreq_q, waitreq_d;
    logic [BE_W-1:0]   be_n_q, be_n_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic [DATA_W-1:0] dq_masked;
    logic              req;

    assign req = !s_chipselect_n && (!s_read_n || !s_write_n);

    // Disabled lanes read back as zero regardless of what the SRAM returns.
    always_comb begin
        dq_masked = '0;
        for (int i = 0; i < BE_W; i++) begin
            if (!be_lat_q[i]) begin
                dq_masked[8*i +: 8] = SRAM_DQ[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        be_lat_d   = be_lat_q;
        wdata_d    = wdata_q;
        wr_acc_d   = wr_acc_q;
        readdata_d = readdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d   = s_address;
                    be_lat_d = s_byteenable_n;
                    wdata_d  = s_writedata;
                    wr_acc_d = !s_write_n;
                    if (!s_write_n) begin
                        state_d = S_WRITE;
                        cnt_d   = 4'(WR_WAIT);
                    end else begin
                        state_d = S_READ;
                        cnt_d   = 4'(RD_WAIT);
                    end
                end
            end
            S_READ: begin
                if (cnt_q == 4'd0) begin
                    state_d    = S_DONE;
                    readdata_d = dq_masked;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WRITE: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                if (TURN > 0) begin
                    state_d = S_TURN;
                    cnt_d   = 4'(TURN - 1);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Pin flops are loaded from the next state so each pin matches the state it is in.
    always_comb begin
        ce_n_d    = !((state_d == S_READ) || (state_d == S_WRITE));
        oe_n_d    = (state_d != S_READ);
        we_n_d    = (state_d != S_WRITE);
        be_n_d    = ce_n_d ? '1 : be_lat_d;
        dq_oe_d   = (state_d == S_WRITE) || ((state_d == S_DONE) && wr_acc_q);
        waitreq_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            be_lat_q   <= '1;
            wdata_q    <= '0;
            wr_acc_q   <= 1'b0;
            readdata_q <= '0;
            waitreq_q  <= 1'b1;
            be_n_q     <= '1;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            be_lat_q   <= be_lat_d;
            wdata_q    <= wdata_d;
            wr_acc_q   <= wr_acc_d;
            readdata_q <= readdata_d;
            waitreq_q  <= waitreq_d;
            be_n_q     <= be_n_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    assign s_readdata    = readdata_q;
    assign s_waitrequest = waitreq_q;
    assign SRAM_ADDR     = addr_q;
    assign SRAM_BE_n     = be_n_q;
    assign SRAM_CE_n     = ce_n_q;
    assign SRAM_OE_n     = oe_n_q;
    assign SRAM_WE_n     = we_n_q;
    assign SRAM_DQ       = dq_oe_q ? wdata_q : {DATA_W{1'bz}};

`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (state_q == S_DONE) begin
            if (wr_acc_q && (wr_cnt_q != 16'hFFFF)) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end
            if (!wr_acc_q && (rd_cnt_q != 16'hFFFF)) begin
                rd_cnt_d = rd_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_q <= 16'd0;
            wr_cnt_q <= 16'd0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`endif

endmodule
